shift_arbiter: RTL
==================

# shift_arbiter

Sequencer and round-robin arbiter that shares one combinational shift unit (SLL/SRL/SRA/ROR) between two requesters. It accepts one command at a time over a valid/ready handshake and normalises the shift amount. It then drives the shared shifter's operand bus, waits a programmable settle time, captures the result and returns it on the winning requester's response channel. It sits between the ALU/control path and the shifter datapath.

## Interface
- SETTLE_CYCLES, 1, cycles the shifter operands are held before capture; legal range 1–15.
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  command valid, per requester.
- req0_ready / req1_ready  out  1  command accepted when valid & ready.
- req0_op / req1_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- req0_data / req1_data  in  8  operand.
- req0_amt / req1_amt  in  8  shift amount, unsigned.
- rsp0_valid / rsp1_valid  out  1  result valid, per requester.
- rsp0_ready / rsp1_ready  in  1  result consumed when valid & ready.
- rsp_data  out  8  result, shared by both response channels.
- sh_op  out  2  to shifter: operation.
- sh_data  out  8  to shifter: operand.
- sh_amt  out  8  to shifter: normalised amount.
- sh_result  in  8  from shifter: result.
- busy  out  1  high in any state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - req*_ready is high only for the requester the arbiter selects this cycle; the other requester sees ready low.
  - With a single valid requester, that requester is selected.
  - With both valid, the requester named by the priority pointer is selected. The pointer resets to 0.
  - On handshake, latch op, data, normalised amount and grant id; go to ISSUE.
  - After a grant, the pointer moves to the other requester.
- **Amount normalisation** (applied at latch time):
  - SLL/SRL with amt ≥ 8: bypass flag set; result is forced to 8'h00.
  - SRA with amt ≥ 8: amt becomes 7, so the result is all sign bits.
  - ROR: amt becomes amt[2:0].
  - All other cases pass amt unchanged (0–7).
- **ISSUE**
  - Drive sh_op/sh_data/sh_amt from the latched registers.
  - Load the settle counter with SETTLE_CYCLES−1.
  - Go to WAIT.
- **WAIT**
  - Keep the sh_* outputs stable.
  - Decrement the counter each cycle.
  - When the counter is 0: capture sh_result into rsp_data (or 8'h00 if the bypass flag is set) and go to RESP.
- **RESP**
  - Assert rsp*_valid for the granted id only; rsp_data is held stable.
  - When that channel's rsp*_ready is high: drop valid and return to IDLE.
  - No new command is accepted until the next IDLE cycle.
- Only the granted requester's rsp*_valid ever rises. The other requester's request is held pending; no command is dropped.

## Timing
- Reset values: req*_ready 0, rsp*_valid 0, rsp_data 0, sh_op 0, sh_data 0, sh_amt 0, busy 0, pointer 0, FSM IDLE.
- Reset is honoured mid-operation at any state; the in-flight command is discarded and no response is produced.
- Handshake at edge T: ISSUE at T+1; WAIT occupies T+2 .. T+1+SETTLE_CYCLES; rsp*_valid first high at T+2+SETTLE_CYCLES.
- With SETTLE_CYCLES=1 and rsp_ready held high, accepts are spaced every 4 cycles.
- The shifter's internal propagation delay (2 time units) is shorter than the clock period. Capturing at the end of WAIT is therefore always settled.
- sh_* outputs change only on the ISSUE edge; they hold their last value while in IDLE.
- req*_ready is a combinational function of state, pointer and the req*_valid inputs. It has no dependence on rsp*_ready.
- rsp*_valid and rsp_data are registered.

## Test plan
- Reset, then req0: SLL, data 8'h81, amt 1 (SETTLE_CYCLES=1). Required: req0_ready high the same cycle; rsp0_valid exactly 3 cycles after the accept edge; rsp_data 8'h02.
- Both requesters valid each cycle. req0 is ROR 8'h96 amt 9; req1 is SRA 8'h80 amt 20. Required grant order: 0, 1, 0, 1. Responses alternate 8'h4B and 8'hFF; sh_amt is 1 and 7 respectively.
- SRL 8'hFF amt 8, then SLL 8'hFF amt 200. Required: rsp_data 8'h00 both times.
- rsp1_ready held low for 5 cycles during RESP, with req0_valid high throughout. Required: rsp1_valid and rsp_data stable; req0_ready low until the cycle after the rsp1 handshake.
- SETTLE_CYCLES=4, with sh_result changing on every cycle of WAIT. Required: the captured value is the one present on the last WAIT cycle; response latency is 6 cycles.
- RESET_N pulsed low during WAIT. Required: all outputs return to reset values immediately; no rsp*_valid is produced; the next request is granted normally with the pointer at 0.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared shifter.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. The sender holds valid and its payload
// steady until that edge; ready may change freely while valid is low.
interface shift_arbiter_if;
  // Command channels (requester -> arbiter)
  logic       req0_valid;
  logic       req0_ready;
  logic [1:0] req0_op;
  logic [7:0] req0_data;
  logic [7:0] req0_amt;
  logic       req1_valid;
  logic       req1_ready;
  logic [1:0] req1_op;
  logic [7:0] req1_data;
  logic [7:0] req1_amt;

  // Response channels (arbiter -> requester), data bus shared by both
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp_data;

  // Shared shifter datapath
  logic [1:0] sh_op;
  logic [7:0] sh_data;
  logic [7:0] sh_amt;
  logic [7:0] sh_result;

  // Status
  logic       busy;

  // Arbiter view
  modport slave (
    input  req0_valid, req0_op, req0_data, req0_amt,
    input  req1_valid, req1_op, req1_data, req1_amt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready,
    output sh_op, sh_data, sh_amt,
    input  sh_result,
    output busy
  );

  // Requester / shifter / environment view
  modport master (
    output req0_valid, req0_op, req0_data, req0_amt,
    output req1_valid, req1_op, req1_data, req1_amt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready,
    input  sh_op, sh_data, sh_amt,
    output sh_result,
    input  busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sequencer sharing one combinational shifter between two
// requesters. One command in flight at a time: accept, drive the shifter,
// wait SETTLE_CYCLES, capture, return the result on the winner's channel.
module shift_arbiter #(
  // Cycles the operands are held on the shifter before capture (1..15)
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  shift_arbiter_if.slave  bus,
  // Debug view of the FSM: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  // Returns {bypass, normalised amount}. Logical shifts of 8 or more always
  // give zero, so they skip the shifter; SRA saturates at 7 (all sign bits);
  // ROR only cares about the amount modulo 8.
  function automatic logic [8:0] normalise(input logic [1:0] op,
                                           input logic [7:0] amt);
    logic [8:0] r;
    r = {1'b0, amt};
    case (op)
      OP_SLL, OP_SRL: if (amt >= 8'd8) r = {1'b1, amt};
      OP_SRA:         if (amt >= 8'd8) r = {1'b0, 8'd7};
      default:        r = {1'b0, 5'd0, amt[2:0]};
    endcase
    return r;
  endfunction

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;       // requester favoured when both are valid
  logic       gnt_q, gnt_d;       // requester owning the command in flight
  logic [1:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic [7:0] amt_q, amt_d;
  logic       byp_q, byp_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_valid_q, rsp_valid_d;

  logic       idle;
  logic       sel1;
  logic       accept;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] cmd_amt;
  logic [8:0] cmd_norm;
  logic       rsp_hs;

  // Arbitration: a lone valid requester wins, otherwise the pointer decides.
  // Ready is held low while reset is asserted.
  always_comb begin
    idle           = (state_q == IDLE);
    sel1           = bus.req1_valid & (~bus.req0_valid | ptr_q);
    bus.req0_ready = rst_ni & idle & bus.req0_valid & ~sel1;
    bus.req1_ready = rst_ni & idle & sel1;
    accept         = bus.req0_ready | bus.req1_ready;
    cmd_op         = sel1 ? bus.req1_op   : bus.req0_op;
    cmd_data       = sel1 ? bus.req1_data : bus.req0_data;
    cmd_amt        = sel1 ? bus.req1_amt  : bus.req0_amt;
    cmd_norm       = normalise(cmd_op, cmd_amt);
    rsp_hs         = gnt_q ? (rsp_valid_q[1] & bus.rsp1_ready)
                           : (rsp_valid_q[0] & bus.rsp0_ready);
  end

  // FSM next state and datapath register updates
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    data_d      = data_q;
    amt_d       = amt_q;
    byp_d       = byp_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = sel1;
          ptr_d   = ~sel1;
          op_d    = cmd_op;
          data_d  = cmd_data;
          byp_d   = cmd_norm[8];
          amt_d   = cmd_norm[7:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = byp_q ? 8'h00 : bus.sh_result;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any command in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      op_q        <= 2'b00;
      data_q      <= 8'h00;
      amt_q       <= 8'h00;
      byp_q       <= 1'b0;
      cnt_q       <= 4'd0;
      rsp_data_q  <= 8'h00;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      byp_q       <= byp_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // The latched command drives the shifter directly, so the operand bus only
  // moves on the accept edge and holds its last value while idle.
  assign bus.sh_op      = op_q;
  assign bus.sh_data    = data_q;
  assign bus.sh_amt     = amt_q;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign state_o        = state_q;

endmodule
